// File: rtl/ikbd_acia_pkg.sv
// ikbd_acia_pkg: shared constants, enums and divide helper for the ikbd-side 6850 ACIA.
package ikbd_acia_pkg;
    localparam int CR_RIE  = 7;
    localparam int SR_RDRF = 0;
    localparam int SR_TDRE = 1;
    localparam int SR_DCD  = 2;
    localparam int SR_CTS  = 3;
    localparam int SR_FE   = 4;
    localparam int SR_OVRN = 5;
    localparam int SR_PE   = 6;
    localparam int SR_IRQ  = 7;

    typedef enum logic [1:0] {DIV1 = 2'b00, DIV16 = 2'b01, DIV64 = 2'b10, MRESET = 2'b11} div_sel_t;

    // One state set serves both serial directions.
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_state_t;

    function automatic logic [6:0] div_n(input logic [1:0] sel);
        return (sel == DIV16) ? 7'd16 : (sel == DIV64) ? 7'd64 : 7'd1;
    endfunction
endpackage

// File: rtl/ikbd_acia_rx.sv
// ikbd_acia_rx: rx synchroniser, 8N1 receive FSM with false-start rejection and framing-error capture.
module ikbd_acia_rx
    import ikbd_acia_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       clr,
    input  logic [6:0] n,
    input  logic       rx,
    output logic       done,
    output logic [7:0] data,
    output logic       fe
);
    ser_state_t st_q, st_d;
    logic [2:0] sync_q, sync_d;
    logic [6:0] cnt_q, cnt_d, half;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d;
    logic       done_q, done_d, fe_q, fe_d, rxs, fall;

    assign done = done_q;
    assign data = sh_q;
    assign fe   = fe_q;

    always_comb begin
        sync_d = {sync_q[1:0], rx};
        rxs    = sync_q[1];
        fall   = sync_q[2] & ~sync_q[1];
        half   = (n[6:1] == 6'd0) ? 7'd1 : {1'b0, n[6:1]};
        st_d   = st_q;
        cnt_d  = clk_en ? cnt_q + 7'd1 : cnt_q;
        bit_d  = bit_q;
        sh_d   = sh_q;
        done_d = 1'b0;
        fe_d   = fe_q;
        unique case (st_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) st_d = START;
            end
            START: if (clk_en && cnt_q >= half - 7'd1) begin
                cnt_d = '0;
                bit_d = '0;
                st_d  = rxs ? IDLE : DATA;
            end
            DATA: if (clk_en && cnt_q >= n - 7'd1) begin
                cnt_d = '0;
                sh_d  = {rxs, sh_q[7:1]};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) st_d = STOP;
            end
            STOP: if (clk_en && cnt_q >= n - 7'd1) begin
                st_d   = IDLE;
                fe_d   = ~rxs;
                done_d = 1'b1;
            end
        endcase
        if (clr) begin
            st_d   = IDLE;
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            st_q   <= IDLE;
            sync_q <= '1;
            cnt_q  <= '0;
            bit_q  <= '0;
            sh_q   <= '0;
            done_q <= 1'b0;
            fe_q   <= 1'b0;
        end else begin
            st_q   <= st_d;
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            sh_q   <= sh_d;
            done_q <= done_d;
            fe_q   <= fe_d;
        end
endmodule

// File: rtl/ikbd_acia.sv
// ikbd_acia: host-side 6850 ACIA on the ikbd serial link, fixed 8N1.
// Define IKBD_ACIA_RX_FIFO_EN to insert an RX_FIFO_DEPTH-entry receive FIFO ahead of RDR.
module ikbd_acia
    import ikbd_acia_pkg::*;
#(
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       res,
    input  logic       clk_en,
    input  logic       cs,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq,
    input  logic       rx,
    output logic       tx
);
    if (RX_FIFO_DEPTH < 2 || RX_FIFO_DEPTH > 16 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("RX_FIFO_DEPTH must be a power of two in 2..16");
    end

    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n      = rst_sync_q[1];
    always_ff @(posedge clk or negedge res)
        if (!res) rst_sync_q <= '0;
        else      rst_sync_q <= rst_sync_d;

    logic [7:0] cr_q, cr_d, dout_q, dout_d, tdr_q, tdr_d, tx_sh_q, tx_sh_d, rdr, status, rx_data;
    logic [6:0] n, tx_cnt_q, tx_cnt_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    ser_state_t tx_st_q, tx_st_d;
    logic tdr_full_q, tdr_full_d, tx_q, tx_d, tx_tick;
    logic wr_cr, wr_dr, rd_dr, mr, mr_d, tie, brk, tdre, rdrf, fe, ovrn, rx_done, rx_fe, unused_cr;

    assign wr_cr     = cs & ~rs & ~rw;
    assign wr_dr     = cs & rs & ~rw;
    assign rd_dr     = cs & rs & rw;
    assign cr_d      = wr_cr ? din : cr_q;
    assign mr_d      = cr_d[1:0] == MRESET;
    assign mr        = cr_q[1:0] == MRESET;
    assign n         = div_n(cr_q[1:0]);
    assign tie       = cr_q[6:5] == 2'b01;
    assign brk       = cr_q[6:5] == 2'b11;
    assign tdre      = ~tdr_full_q & ~mr;
    assign irq       = (cr_q[CR_RIE] & (rdrf | ovrn)) | (tie & tdre);
    assign status    = {irq, 1'b0, ovrn, fe, 1'b0, 1'b0, tdre, rdrf};
    assign dout_d    = (cs & rw) ? (rs ? rdr : status) : dout_q;
    assign dout      = dout_q;
    assign tx        = tx_q;
    assign unused_cr = ^cr_q[4:2];

    ikbd_acia_rx u_rx (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .clr    (mr_d),
        .n      (n),
        .rx     (rx),
        .done   (rx_done),
        .data   (rx_data),
        .fe     (rx_fe)
    );

`ifdef IKBD_ACIA_RX_FIFO_EN
    localparam int AW = $clog2(RX_FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(RX_FIFO_DEPTH);
    logic [8:0]    mem_q [RX_FIFO_DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovrn_q, ovrn_d, push, pop;
    always_comb begin
        pop    = rd_dr && cnt_q != '0;
        push   = rx_done && (cnt_q != FULL || pop);
        wp_d   = wp_q + AW'(push);
        rp_d   = rp_q + AW'(pop);
        cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        ovrn_d = (rx_done && !push) || (ovrn_q && !rd_dr);
        if (mr_d) begin
            wp_d   = '0;
            rp_d   = '0;
            cnt_d  = '0;
            ovrn_d = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            ovrn_q <= 1'b0;
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            ovrn_q <= ovrn_d;
        end
    always_ff @(posedge clk)
        if (push) mem_q[wp_q] <= {rx_fe, rx_data};
    assign rdrf = cnt_q != '0;
    assign fe   = rdrf & mem_q[rp_q][8];
    assign rdr  = rdrf ? mem_q[rp_q][7:0] : 8'h00;
    assign ovrn = ovrn_q;
`else
    logic [7:0] rdr_q, rdr_d;
    logic       rdrf_q, rdrf_d, ovrn_q, ovrn_d, fe_q, fe_d;
    always_comb begin
        rdr_d  = rdr_q;
        rdrf_d = rdrf_q & ~rd_dr;
        ovrn_d = ovrn_q & ~rd_dr;
        fe_d   = fe_q & ~rd_dr;
        // A byte landing in the same cycle as the read is kept, not counted as overrun.
        if (rx_done) begin
            if (rdrf_q && !rd_dr) ovrn_d = 1'b1;
            else begin
                rdr_d  = rx_data;
                rdrf_d = 1'b1;
                fe_d   = rx_fe;
            end
        end
        if (mr_d) begin
            rdrf_d = 1'b0;
            ovrn_d = 1'b0;
            fe_d   = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rdr_q  <= '0;
            rdrf_q <= 1'b0;
            ovrn_q <= 1'b0;
            fe_q   <= 1'b0;
        end else begin
            rdr_q  <= rdr_d;
            rdrf_q <= rdrf_d;
            ovrn_q <= ovrn_d;
            fe_q   <= fe_d;
        end
    assign rdr  = rdr_q;
    assign rdrf = rdrf_q;
    assign ovrn = ovrn_q;
    assign fe   = fe_q;
`endif

    always_comb begin
        tx_tick    = clk_en & (tx_cnt_q >= n - 7'd1);
        tx_cnt_d   = tx_tick ? 7'd0 : clk_en ? tx_cnt_q + 7'd1 : tx_cnt_q;
        tx_st_d    = tx_st_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_d       = tx_q;
        tdr_d      = wr_dr ? din : tdr_q;
        tdr_full_d = tdr_full_q;
        unique case (tx_st_q)
            IDLE: begin
                tx_d = ~brk;
                if (tx_tick && tdr_full_q && !brk) begin
                    tx_st_d    = START;
                    tx_sh_d    = tdr_q;
                    tdr_full_d = 1'b0;
                    tx_d       = 1'b0;
                end
            end
            START: if (tx_tick) begin
                tx_st_d  = DATA;
                tx_bit_d = '0;
                tx_d     = tx_sh_q[0];
            end
            DATA: if (tx_tick) begin
                tx_bit_d = tx_bit_q + 3'd1;
                tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                tx_d     = (tx_bit_q == 3'd7) ? 1'b1 : tx_sh_q[1];
                if (tx_bit_q == 3'd7) tx_st_d = STOP;
            end
            STOP: if (tx_tick) begin
                tx_st_d = IDLE;
                tx_d    = ~brk;
            end
        endcase
        if (wr_dr) tdr_full_d = 1'b1;
        // Master reset abandons any frame immediately, including one written this cycle.
        if (mr_d) begin
            tx_st_d    = IDLE;
            tx_cnt_d   = '0;
            tdr_full_d = 1'b0;
            tx_d       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cr_q       <= 8'h03;
            dout_q     <= '0;
            tdr_q      <= '0;
            tdr_full_q <= 1'b0;
            tx_st_q    <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            cr_q       <= cr_d;
            dout_q     <= dout_d;
            tdr_q      <= tdr_d;
            tdr_full_q <= tdr_full_d;
            tx_st_q    <= tx_st_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_q       <= tx_d;
        end
endmodule

// File: tb/tb_ikbd_acia.sv
// tb_ikbd_acia: directed bench for ikbd_acia at /64 with clk_en every 4 clk (256 clk per bit).
module tb_ikbd_acia;
    logic       clk = 1'b0, res = 1'b1, clk_en = 1'b0, cs = 1'b0, rs = 1'b0, rw = 1'b1, rx = 1'b1;
    logic [7:0] din = 8'h00, d;
    logic [7:0] dout;
    logic       irq, tx;
    logic [9:0] frame;
    int         npass = 0, nfail = 0, ntotal = 0, k;

    ikbd_acia dut (
        .clk    (clk),
        .res    (res),
        .clk_en (clk_en),
        .cs     (cs),
        .rs     (rs),
        .rw     (rw),
        .din    (din),
        .dout   (dout),
        .irq    (irq),
        .rx     (rx),
        .tx     (tx)
    );

    always #5 clk = ~clk;

    initial forever begin
        repeat (3) @(negedge clk);
        clk_en = 1'b1;
        @(negedge clk);
        clk_en = 1'b0;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic a, input logic [7:0] v);
        @(negedge clk);
        cs = 1'b1; rs = a; rw = 1'b0; din = v;
        @(negedge clk);
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic rd(input logic a, output logic [7:0] v);
        @(negedge clk);
        cs = 1'b1; rs = a; rw = 1'b1;
        @(negedge clk);
        cs = 1'b0;
        v = dout;
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (256) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (256) @(negedge clk);
        end
        rx = stop;
        repeat (256) @(negedge clk);
        rx = 1'b1;
        repeat (256) @(negedge clk);
    endtask

    task automatic wait_tx_fall();
        for (k = 0; k < 1000 && tx; k++) @(negedge clk);
        chk("tx_start_seen", 8'(k < 1000), 8'h01);
    endtask

    initial begin
        #3 res = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_dout", dout, 8'h00);
        chk("rst_irq", irq, 1'b0);
        chk("rst_tx", tx, 1'b1);
        res = 1'b1;
        repeat (4) @(negedge clk);
        rd(0, d); chk("sr_mreset", d, 8'h00);

        wr(0, 8'h03);
        wr(0, 8'h96);
        rd(0, d); chk("sr_after_cr96", d, 8'h02);
        chk("irq_idle", irq, 1'b0);
        chk("tx_idle", tx, 1'b1);

        send(8'hA5, 1'b1);
        repeat (100) @(negedge clk);
        chk("irq_rdrf", irq, 1'b1);
        rd(0, d); chk("sr_rdrf", d, 8'h83);
        rd(1, d); chk("rdr_a5", d, 8'hA5);
        rd(0, d); chk("sr_after_read", d, 8'h02);
        chk("irq_cleared", irq, 1'b0);

        send(8'h12, 1'b1);
        send(8'h34, 1'b1);
        repeat (100) @(negedge clk);
`ifdef IKBD_ACIA_RX_FIFO_EN
        rd(0, d); chk("sr_two_bytes", d, 8'h83);
        rd(1, d); chk("rdr_first", d, 8'h12);
        rd(1, d); chk("rdr_second", d, 8'h34);
`else
        rd(0, d); chk("sr_ovrn", d, 8'hA3);
        rd(1, d); chk("rdr_kept", d, 8'h12);
`endif
        rd(0, d); chk("sr_ovrn_cleared", d, 8'h02);

        send(8'h55, 1'b0);
        repeat (100) @(negedge clk);
        rd(0, d); chk("sr_fe", d, 8'h93);
        rd(1, d); chk("rdr_55", d, 8'h55);
        rd(0, d); chk("sr_fe_cleared", d, 8'h02);

        @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (1000) @(negedge clk);
        rd(0, d); chk("sr_glitch", d, 8'h02);

        wr(0, 8'hB6);
        chk("irq_tie_tdre", irq, 1'b1);
        wr(1, 8'h80);
        chk("irq_tdr_full", irq, 1'b0);
        wait_tx_fall();
        chk("irq_tdre_reload", irq, 1'b1);
        frame = {1'b1, 8'h80, 1'b0};
        repeat (128) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("tx_bit%0d", i), tx, frame[i]);
            repeat (256) @(negedge clk);
        end
        repeat (300) @(negedge clk);
        chk("tx_idle_after", tx, 1'b1);

        wr(0, 8'h96);
        wr(1, 8'hFF);
        wait_tx_fall();
        repeat (50) @(negedge clk);
        chk("tx_start_bit", tx, 1'b0);
        wr(0, 8'h03);
        chk("tx_mreset", tx, 1'b1);
        rd(0, d); chk("sr_mreset_held", d, 8'h00);
        repeat (600) @(negedge clk);
        chk("tx_mreset_held", tx, 1'b1);
        rd(0, d); chk("sr_tdre_low", d, 8'h00);
        wr(0, 8'h96);
        rd(0, d); chk("sr_released", d, 8'h02);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule

// File: doc/ikbd_acia.md
Name: ikbd_acia

Overview:
- Host-side 6850-compatible ACIA that terminates the ikbd serial link: deserialises ikbd tx, serialises host commands onto ikbd rx.
- Exposes the 6850 register pair (control/status, tx/rx data) and IRQ to the 68000 bus glue.
- Sits directly downstream of the ikbd block's tx and upstream of its rx.
- Fixed 8N1 framing. Standard ST divide is /64 on a 500 kHz bit-clock enable, giving 7812.5 baud.

Parameters:
- RX_FIFO_DEPTH, 4: receive FIFO entries. Used only when IKBD_ACIA_RX_FIFO_EN is defined; power of two, range 2..16.

Ports:
- clk  in  1  system clock, same domain as ikbd
- res  in  1  reset; asynchronous assert, active-low (0 = reset); deassertion synchronised internally
- clk_en  in  1  single-cycle bit-clock enable; all serial timing advances only on clk_en=1
- cs  in  1  register access strobe, exactly one clk cycle per access
- rs  in  1  register select: 0 = control/status, 1 = data
- rw  in  1  1 = read, 0 = write
- din  in  8  write data
- dout  out  8  read data, registered, valid the cycle after cs
- irq  out  1  interrupt request, active-high (bus glue inverts)
- rx  in  1  serial in, connected to ikbd tx; idle 1
- tx  out  1  serial out, connected to ikbd rx; idle 1

Behaviour:
- Reset: dout=0x00, irq=0, tx=1. CR=0x03 (master reset held). All status bits 0 except TDRE=0. Shifters idle.
- CR write (rs=0, rw=0): CR<=din.
  - CR1:0: 00 = /1, 01 = /16, 10 = /64, 11 = master reset. Master reset clears RDRF, OVRN, FE, both shifters and the FIFO; tx=1; TDRE=0 while held.
  - CR4:2: stored, ignored; framing is always 8N1.
  - CR6:5: 00 = RTS, TIE off; 01 = TIE on; 10 = TIE off; 11 = break (tx=0 continuously after the current frame, TIE off).
  - CR7: RIE.
- Status (rs=0, rw=1): b0 RDRF, b1 TDRE, b2 DCD=0, b3 CTS=0, b4 FE, b5 OVRN, b6 PE=0, b7 IRQ.
- irq = (RIE & (RDRF | OVRN)) | (TIE & TDRE). Combinational from registered state, not gated by master reset except through the cleared flags.
- RX path:
  - rx passes a 2-FF synchroniser. Divide N = 1, 16 or 64 ticks/bit.
  - IDLE -> START on synced falling edge.
  - START samples at tick N/2. If rx=1, it is a false start: back to IDLE. For /1, sample on the next tick.
  - DATA: 8 bits sampled LSB first, each N ticks later. Then STOP.
  - STOP: FE = ~rx. Load RDR, set RDRF, return to IDLE.
  - If RDRF is already set at STOP: byte discarded, OVRN=1, RDR unchanged.
- RDR read (rs=1, rw=1): dout=RDR; clears RDRF, OVRN and FE in the same cycle. A byte completing in that same cycle wins: RDRF ends at 1.
- TX path:
  - TDR write (rs=1, rw=0) while TDRE=1: TDR<=din, TDRE=0. Write while TDRE=0 overwrites TDR and is not flagged.
  - Transmitter IDLE and TDRE=0: on the next bit boundary, load the shifter and set TDRE=1.
  - Frame: start 0, d0..d7, stop 1; each bit lasts N ticks.
  - First TDRE rise after master-reset release: TDRE=1 within 1 clk.
- Simultaneous CR write to master reset during an active frame: frame abandoned immediately; tx=1 the next clk.
- Reads of the write-only registers have no side effects. cs with rw=0 leaves dout unchanged.

Optional Feature:
- IKBD_ACIA_RX_FIFO_EN defined: an RX_FIFO_DEPTH-entry FIFO sits between the RX shifter and RDR.
  - RDRF = FIFO non-empty; an RDR read pops.
  - OVRN is set only when a byte completes while the FIFO is full; that byte is dropped.
  - FE is stored per entry and reported for the head entry.
- Undefined: single RDR, behaviour exactly as above. Register map and timing are otherwise identical.

Decomposition:
- Package ikbd_acia_pkg:
  - CR/SR bit index constants
  - divide-select enum (DIV1, DIV16, DIV64, MRESET)
  - rx/tx state enums (IDLE, START, DATA, STOP)
  - function returning N from CR1:0
- Sub-module ikbd_acia_rx (synchroniser + RX FSM + FE detection), instantiated once. TX FSM and register file stay in the top.

Test Plan:
- Reset, then CR write 0x03 followed by 0x96 -> status reads 0x02 (TDRE only), irq=0, tx=1.
- CR=0x96, clk_en every 4 clk; drive rx with byte 0xA5 (8N1, 256 clk/bit) -> RDRF=1, irq=1, status 0x83; RDR read returns 0xA5, then status 0x02, irq=0.
- Two bytes 0x12 then 0x34 without reading -> OVRN=1 and RDR=0x12 (FIFO undefined). With IKBD_ACIA_RX_FIFO_EN defined: reads return 0x12 then 0x34 and OVRN=0.
- CR=0xB6 (TIE), write TDR=0x80 -> tx shows 0, 0000000 1, 1 at 256 clk/bit; TDRE re-asserts at shifter load; irq follows TDRE.
- rx stop bit held 0 on byte 0x55 -> FE=1 (status b4); cleared by RDR read.
- Glitch of rx=0 for 16 clk at /64 -> false start rejected, RDRF stays 0.
- Master reset mid-frame during TX of 0xFF -> tx=1 the next clk, TDRE=0 until CR written 0x96.
